// File: rtl/uart_frame_counter.sv
// Bit/frame sequencer for the UART transmitter: counts baud ticks per bit and
// steps through START, DATA, optional PARITY and 1-2 STOP bits.
module uart_frame_counter #(
  parameter int OVERSAMPLE    = 16,
  parameter int MAX_DATA_BITS = 9,
  parameter int IDX_W         = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             tick_i,
  input  logic             clear_i,
  input  logic [3:0]       data_bits_i,
  input  logic             parity_en_i,
  input  logic             stop2_i,
  output logic             busy_o,
  output logic [2:0]       phase_o,
  output logic [IDX_W-1:0] bit_idx_o,
  output logic             bit_strobe_o,
  output logic             frame_done_o,
  output logic             cfg_err_o
);

  localparam int              CNT_W     = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       MAX_N     = 4'(MAX_DATA_BITS);

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_START  = 3'd1,
    PH_DATA   = 3'd2,
    PH_PARITY = 3'd3,
    PH_STOP   = 3'd4
  } phase_t;

  phase_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic [3:0]       n_cfg;
  logic             parity_cfg;
  logic             stop2_cfg;

  logic bit_end;
  logic len_ok;
  logic data_last;
  logic stop_last;

  assign bit_end   = tick_i && (tick_cnt == TICK_LAST);
  assign len_ok    = (data_bits_i >= 4'd5) && (data_bits_i <= MAX_N);
  assign data_last = (bit_idx_o == IDX_W'(n_cfg - 4'd1));
  assign stop_last = (bit_idx_o == IDX_W'(stop2_cfg));

  // The FSM state is the phase code, so phase_o doubles as the state debug view.
  assign phase_o = state;

  // start_i is a level request: it is accepted on any edge where the block is
  // IDLE and clear_i is low, and ignored entirely while a frame is in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state        <= PH_IDLE;
      busy_o       <= 1'b0;
      bit_idx_o    <= '0;
      tick_cnt     <= '0;
      bit_strobe_o <= 1'b0;
      frame_done_o <= 1'b0;
      cfg_err_o    <= 1'b0;
      n_cfg        <= '0;
      parity_cfg   <= 1'b0;
      stop2_cfg    <= 1'b0;
    end else begin
      bit_strobe_o <= 1'b0;
      frame_done_o <= 1'b0;
      cfg_err_o    <= 1'b0;
      if (state == PH_IDLE) begin
        if (start_i) begin
          if (len_ok) begin
            state      <= PH_START;
            busy_o     <= 1'b1;
            n_cfg      <= data_bits_i;
            parity_cfg <= parity_en_i;
            stop2_cfg  <= stop2_i;
            tick_cnt   <= '0;
            bit_idx_o  <= '0;
          end else begin
            cfg_err_o <= 1'b1;
          end
        end
      end else if (tick_i) begin
        if (!bit_end) begin
          tick_cnt <= tick_cnt + CNT_W'(1);
        end else begin
          tick_cnt     <= '0;
          bit_strobe_o <= 1'b1;
          case (state)
            PH_START: begin
              state     <= PH_DATA;
              bit_idx_o <= '0;
            end
            PH_DATA: begin
              if (data_last) begin
                state     <= parity_cfg ? PH_PARITY : PH_STOP;
                bit_idx_o <= '0;
              end else begin
                bit_idx_o <= bit_idx_o + IDX_W'(1);
              end
            end
            PH_PARITY: begin
              state     <= PH_STOP;
              bit_idx_o <= '0;
            end
            PH_STOP: begin
              if (stop_last) begin
                state        <= PH_IDLE;
                busy_o       <= 1'b0;
                frame_done_o <= 1'b1;
                bit_idx_o    <= '0;
              end else begin
                bit_idx_o <= bit_idx_o + IDX_W'(1);
              end
            end
            default: begin
              state     <= PH_IDLE;
              busy_o    <= 1'b0;
              bit_idx_o <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_counter.sv
// Bench for uart_frame_counter: a tick-count frame model checked every cycle,
// plus directed frames with hand-computed lengths, strobe counts and indices.
module tb_uart_frame_counter;

  localparam int OS   = 16;
  localparam int MAXN = 9;
  localparam int IW   = 4;

  logic          clk = 1'b0;
  logic          rst, start, tick, clear, parity_en, stop2;
  logic [3:0]    data_bits;
  logic          busy;
  logic [2:0]    phase;
  logic [IW-1:0] bit_idx;
  logic          bit_strobe, frame_done, cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  uart_frame_counter #(
    .OVERSAMPLE(OS), .MAX_DATA_BITS(MAXN), .IDX_W(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .tick_i(tick), .clear_i(clear),
    .data_bits_i(data_bits), .parity_en_i(parity_en), .stop2_i(stop2),
    .busy_o(busy), .phase_o(phase), .bit_idx_o(bit_idx),
    .bit_strobe_o(bit_strobe), .frame_done_o(frame_done), .cfg_err_o(cfg_err)
  );

  // ---------------- clock / tick generation ----------------
  always #5 clk = ~clk;

  int   cyc         = 0;
  int   tick_ref    = 0;
  int   tick_period = 1;
  logic tick_hold   = 1'b0;

  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      tick = (tick_period > 0) && !tick_hold &&
             (((cyc + 1 - tick_ref) % tick_period) == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic       s_rst, s_start, s_tick, s_clear, s_par, s_stop2;
  logic [3:0] s_n;
  bit         seen_rst = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      s_rst = rst; s_start = start; s_tick = tick; s_clear = clear;
      s_par = parity_en; s_stop2 = stop2; s_n = data_bits;
    end
  end

  bit m_active = 1'b0;
  int m_ticks, m_n, m_p, m_s, b;
  int e_phase, e_idx;
  bit e_strobe, e_done, e_err;

  initial begin
    forever begin
      @(negedge clk);
      if (s_rst) seen_rst = 1'b1;
      e_strobe = 1'b0; e_done = 1'b0; e_err = 1'b0;
      if (s_rst || s_clear) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        if (s_start) begin
          if (s_n >= 5 && s_n <= MAXN) begin
            m_active = 1'b1; m_ticks = 0;
            m_n = int'(s_n); m_p = s_par ? 1 : 0; m_s = s_stop2 ? 2 : 1;
          end else begin
            e_err = 1'b1;
          end
        end
      end else if (s_tick) begin
        m_ticks++;
        if (m_ticks % OS == 0) begin
          e_strobe = 1'b1;
          if (m_ticks == OS * (1 + m_n + m_p + m_s)) begin
            m_active = 1'b0; e_done = 1'b1;
          end
        end
      end
      e_phase = 0; e_idx = 0;
      if (m_active) begin
        b = m_ticks / OS;
        if (b == 0) e_phase = 1;
        else if (b <= m_n) begin e_phase = 2; e_idx = b - 1; end
        else if (m_p == 1 && b == m_n + 1) e_phase = 3;
        else begin e_phase = 4; e_idx = b - 1 - m_n - m_p; end
      end
      if (seen_rst) begin
        check("busy", busy, m_active);
        check("phase", phase, e_phase);
        check("bit_idx", bit_idx, e_idx);
        check("bit_strobe", bit_strobe, e_strobe);
        check("frame_done", frame_done, e_done);
        check("cfg_err", cfg_err, e_err);
      end
    end
  end

  // ---------------- driver tasks ----------------
  int r_cycles, r_strobes, r_max_d, r_max_s, r_busy_done;
  bit r_saw_par;

  task automatic start_frame(input int n, input bit p, input bit s2, input int per);
    data_bits = 4'(n); parity_en = p; stop2 = s2;
    tick_period = per; tick_ref = cyc + 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs from the slot after a start edge until frame_done_o, recording stats.
  task automatic measure_frame(input int hold_at, input int hold_len, input int poke_at);
    r_cycles = 0; r_strobes = 0; r_max_d = -1; r_max_s = -1; r_saw_par = 1'b0;
    while (!frame_done && r_cycles < 2000) begin
      if (r_cycles == hold_at) tick_hold = 1'b1;
      if (r_cycles == hold_at + hold_len) tick_hold = 1'b0;
      if (poke_at >= 0) begin
        start = (r_cycles == poke_at);
        if (r_cycles == poke_at) data_bits = 4'd3;
      end
      @(posedge clk); #1;
      r_cycles++;
      if (bit_strobe) r_strobes++;
      if (phase == 3'd2 && int'(bit_idx) > r_max_d) r_max_d = int'(bit_idx);
      if (phase == 3'd4 && int'(bit_idx) > r_max_s) r_max_s = int'(bit_idx);
      if (phase == 3'd3) r_saw_par = 1'b1;
    end
    tick_hold = 1'b0;
    r_busy_done = busy;
    check("frame_done_seen", frame_done, 1);
  endtask

  task automatic bad_start(input int n);
    int errs;
    data_bits = 4'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("bad_cfg_err", cfg_err, 1);
    check("bad_busy", busy, 0);
    check("bad_phase", phase, 0);
    errs = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (cfg_err) errs++;
    end
    check("bad_err_single", errs, 0);
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    int w, dones;
    rst = 1'b1; start = 1'b0; clear = 1'b0;
    data_bits = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_phase", phase, 0);
    check("rst_idx", bit_idx, 0);
    check("rst_strobe", bit_strobe, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", cfg_err, 0);
    repeat (2) @(posedge clk);
    #1;

    // N=8, no parity, 1 stop, tick every cycle: 10 bits * 16 = 160 cycles
    start_frame(8, 1'b0, 1'b0, 1);
    measure_frame(-1, 0, -1);
    check("t1_cycles", r_cycles, 160);
    check("t1_strobes", r_strobes, 10);
    check("t1_busy_at_done", r_busy_done, 0);
    check("t1_max_data_idx", r_max_d, 7);
    check("t1_parity_skipped", r_saw_par, 0);
    repeat (3) @(posedge clk);
    #1;

    // N=7, parity, 2 stops, tick every 3rd cycle: 11 bits * 16 ticks * 3
    start_frame(7, 1'b1, 1'b1, 3);
    measure_frame(-1, 0, 100);
    check("t2_cycles", r_cycles, 528);
    check("t2_strobes", r_strobes, 11);
    check("t2_max_data_idx", r_max_d, 6);
    check("t2_max_stop_idx", r_max_s, 1);
    check("t2_parity_seen", r_saw_par, 1);
    tick_period = 1;
    repeat (3) @(posedge clk);
    #1;

    bad_start(4);
    bad_start(10);

    // clear in DATA at bit 3 with start also high
    start_frame(8, 1'b0, 1'b0, 1);
    w = 0;
    while (!(phase == 3'd2 && bit_idx == 4'd3) && w < 200) begin
      @(posedge clk); #1; w++;
    end
    check("t4_reach_data3", (w < 200), 1);
    clear = 1'b1; start = 1'b1; dones = 0;
    @(posedge clk); #1;
    if (frame_done) dones++;
    check("t4_clr_busy", busy, 0);
    check("t4_clr_phase", phase, 0);
    check("t4_clr_idx", bit_idx, 0);
    check("t4_clr_strobe", bit_strobe, 0);
    repeat (2) begin
      @(posedge clk); #1;
      if (frame_done) dones++;
    end
    check("t4_held_clear_busy", busy, 0);
    clear = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("t4_restart_busy", busy, 1);
    check("t4_restart_phase", phase, 1);
    check("t4_no_done_on_abort", dones, 0);
    measure_frame(-1, 0, -1);
    check("t4_cycles", r_cycles, 160);
    repeat (3) @(posedge clk);
    #1;

    // ticks withheld for 50 cycles during START
    start_frame(8, 1'b0, 1'b0, 1);
    measure_frame(5, 50, -1);
    check("t5_cycles", r_cycles, 210);
    check("t5_strobes", r_strobes, 10);
    repeat (3) @(posedge clk);
    #1;

    // start held high: back-to-back N=5 frames of 7 bits = 112 cycles
    data_bits = 4'd5; parity_en = 1'b0; stop2 = 1'b0; tick_period = 1;
    start = 1'b1;
    @(posedge clk); #1;
    measure_frame(-1, 0, -1);
    check("t6_first_cycles", r_cycles, 112);
    @(posedge clk); #1;
    check("t6_restart_phase", phase, 1);
    check("t6_restart_busy", busy, 1);
    measure_frame(-1, 0, -1);
    check("t6_second_cycles", r_cycles, 112);
    start = 1'b0;
    @(posedge clk); #1;
    check("t6_idle_after", busy, 0);
    repeat (3) @(posedge clk);
    #1;

    // reset mid-frame behaves like clear
    start_frame(9, 1'b1, 1'b1, 1);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_phase", phase, 0);
    check("rst_mid_done", frame_done, 0);
    repeat (5) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
